dac_pulse_driver: RTL and testbench

//  Parametrised multi-channel DAC front end for the ReRAM crossbar row/column drivers.

---
 rtl/dac_pulse_driver.sv | 204 ++++++++++++++++++++
 tb/tb_dac_pulse_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_pulse_driver.sv
// Multi-channel DAC front end for the ReRAM crossbar line drivers.
// Runs one command at a time: ramp enabled channels to target, hold for the pulse width, then recover.
module dac_pulse_driver #(
    parameter int                N_CH      = 4,
    parameter int                DATA_W    = 8,
    parameter int                W_W       = 8,
    parameter int                RAMP_STEP = 16,
    parameter int                RECOV_CYC = 4,
    parameter logic [DATA_W-1:0] READ_CODE = 8'h20
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_mode_i,
    input  logic [W_W-1:0]         cmd_width_i,
    input  logic [N_CH*DATA_W-1:0] cmd_code_i,
    input  logic [N_CH-1:0]        cmd_mask_i,
    input  logic                   abort_i,
    output logic [N_CH*DATA_W-1:0] dac_o,
    output logic [N_CH-1:0]        dac_en_o,
    output logic                   polarity_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic                   err_o
);
    localparam int RC_W = (RECOV_CYC > 1) ? $clog2(RECOV_CYC) : 1;
    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_RESET = 2'b10;
    localparam logic [1:0] MODE_ILL   = 2'b11;
    localparam logic [DATA_W:0] STEP_X = (DATA_W+1)'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RAMP, PULSE, RECOVER} state_t;

    state_t                       state_q, state_d;
    logic [N_CH-1:0][DATA_W-1:0]  cur_q, cur_d;
    logic [N_CH-1:0][DATA_W-1:0]  tgt_q, tgt_d;
    logic [N_CH-1:0]              mask_q, mask_d;
    logic                         neg_q, neg_d;
    logic [W_W-1:0]               cnt_q, cnt_d;
    logic [RC_W-1:0]              rcnt_q, rcnt_d;
    logic                         abrt_q, abrt_d;
    logic                         ready_q, ready_d;
    logic                         busy_q, busy_d;
    logic [N_CH-1:0]              en_q, en_d;
    logic                         pol_q, pol_d;
    logic                         done_q, done_d;
    logic                         aborted_q, aborted_d;
    logic                         err_q, err_d;

    logic [N_CH-1:0][DATA_W-1:0]  in_tgt;
    logic [N_CH-1:0][DATA_W-1:0]  tgt_sel;
    logic [N_CH-1:0][DATA_W-1:0]  ramp;
    logic [N_CH-1:0][DATA_W:0]    sum_w;
    logic                         active_d;

    // Effective targets of the incoming command; disabled channels target zero.
    always_comb begin
        in_tgt = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cmd_mask_i[k]) begin
                in_tgt[k] = (cmd_mode_i == MODE_READ) ? READ_CODE
                                                      : cmd_code_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign tgt_sel = (state_q == IDLE) ? in_tgt : tgt_q;

    // One saturating ramp step per channel, computed one bit wider so it cannot wrap.
    always_comb begin
        ramp  = '0;
        sum_w = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum_w[k] = {1'b0, cur_q[k]} + STEP_X;
            if (sum_w[k] > {1'b0, tgt_sel[k]}) begin
                ramp[k] = tgt_sel[k];
            end else begin
                ramp[k] = sum_w[k][DATA_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        mask_d  = mask_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        abrt_d  = abrt_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_mode_i == MODE_ILL || cmd_width_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d  = in_tgt;
                        mask_d = cmd_mask_i;
                        neg_d  = (cmd_mode_i == MODE_RESET);
                        cnt_d  = cmd_width_i - W_W'(1);
                        abrt_d = 1'b0;
                        if (RAMP_STEP == 0 || cmd_mode_i == MODE_READ || in_tgt == '0) begin
                            state_d = PULSE;
                            cur_d   = in_tgt;
                        end else begin
                            state_d = RAMP;
                            cur_d   = ramp;
                        end
                    end
                end
            end
            RAMP: begin
                if (abort_i) begin
                    state_d = RECOVER;
                    cur_d   = '0;
                    rcnt_d  = RC_W'(RECOV_CYC - 1);
                    abrt_d  = 1'b1;
                end else if (cur_q == tgt_q) begin
                    state_d = PULSE;
                end else begin
                    cur_d = ramp;
                end
            end
            PULSE: begin
                if (abort_i || cnt_q == '0) begin
                    state_d = RECOVER;
                    cur_d   = '0;
                    rcnt_d  = RC_W'(RECOV_CYC - 1);
                    abrt_d  = abort_i;
                end else begin
                    cnt_d = cnt_q - W_W'(1);
                end
            end
            RECOVER: begin
                if (rcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q - RC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        active_d  = (state_d == RAMP) || (state_d == PULSE);
        en_d      = active_d ? mask_d : '0;
        pol_d     = active_d & neg_d;
        busy_d    = (state_d != IDLE);
        ready_d   = (state_d == IDLE);
        done_d    = (state_d == RECOVER) && (rcnt_d == '0);
        aborted_d = done_d & abrt_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            tgt_q     <= '0;
            mask_q    <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            abrt_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            en_q      <= '0;
            pol_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            mask_q    <= mask_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            abrt_q    <= abrt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            pol_q     <= pol_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
        end
    end

    assign dac_o       = cur_q;
    assign dac_en_o    = en_q;
    assign polarity_o  = pol_q;
    assign busy_o      = busy_q;
    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_dac_pulse_driver.sv
// Bench for dac_pulse_driver: a queue-based trace model predicts every output cycle,
// directed scenarios pin known literal values, then randomized commands and aborts.
module tb_dac_pulse_driver;
    localparam int N_CH      = 4;
    localparam int DATA_W    = 8;
    localparam int W_W       = 8;
    localparam int RAMP_STEP = 16;
    localparam int RECOV_CYC = 4;
    localparam int READ_VAL  = 'h20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_mode_i;
    logic [7:0]  cmd_width_i;
    logic [31:0] cmd_code_i;
    logic [3:0]  cmd_mask_i;
    logic        abort_i;
    logic [31:0] dac_o;
    logic [3:0]  dac_en_o;
    logic        polarity_o, busy_o, done_o, aborted_o, err_o;

    int checks   = 0;
    int failures = 0;

    dac_pulse_driver #(
        .N_CH(N_CH), .DATA_W(DATA_W), .W_W(W_W), .RAMP_STEP(RAMP_STEP),
        .RECOV_CYC(RECOV_CYC), .READ_CODE(8'h20)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_mode_i(cmd_mode_i), .cmd_width_i(cmd_width_i),
        .cmd_code_i(cmd_code_i), .cmd_mask_i(cmd_mask_i),
        .abort_i(abort_i),
        .dac_o(dac_o), .dac_en_o(dac_en_o), .polarity_o(polarity_o),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // One expected output cycle; 'active' marks a ramp/hold cycle where abort is honoured.
    typedef struct packed {
        logic [31:0] dac;
        logic [3:0]  en;
        logic        pol, ready, busy, done, aborted, err, active;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;

    function automatic exp_t idleRec();
        exp_t r;
        r       = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pushRecover(input logic ab);
        exp_t r;
        for (int i = 1; i <= RECOV_CYC; i++) begin
            r      = '0;
            r.busy = 1'b1;
            if (i == RECOV_CYC) begin
                r.done    = 1'b1;
                r.aborted = ab;
            end
            exp_q.push_back(r);
        end
    endtask

    // Whole-command trace: ramp cycles reach each target at min(i*step, target), then hold, then recover.
    task automatic buildSeq(input logic [1:0] mode, input int width, input logic [31:0] code, input logic [3:0] mask);
        int   tgt[4];
        int   n;
        int   v;
        exp_t r;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            tgt[k] = !mask[k] ? 0 : (mode == 2'b00) ? READ_VAL : int'(code[8*k +: 8]);
            if (RAMP_STEP != 0 && mode != 2'b00 && (tgt[k] + RAMP_STEP - 1) / RAMP_STEP > n)
                n = (tgt[k] + RAMP_STEP - 1) / RAMP_STEP;
        end
        for (int i = 1; i <= n + width; i++) begin
            r        = '0;
            r.busy   = 1'b1;
            r.active = 1'b1;
            r.en     = mask;
            r.pol    = (mode == 2'b10);
            for (int k = 0; k < 4; k++) begin
                v = (i * RAMP_STEP < tgt[k] && i <= n) ? i * RAMP_STEP : tgt[k];
                r.dac[8*k +: 8] = 8'(v);
            end
            exp_q.push_back(r);
        end
        pushRecover(1'b0);
    endtask

    // Reference model: advances one expected cycle per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            cur_exp = idleRec();
        end else if (!cur_exp.busy) begin
            cur_exp = idleRec();
            if (cmd_valid_i) begin
                if (cmd_mode_i == 2'b11 || cmd_width_i == 8'd0) begin
                    cur_exp.err = 1'b1;
                end else begin
                    buildSeq(cmd_mode_i, int'(cmd_width_i), cmd_code_i, cmd_mask_i);
                    cur_exp = exp_q.pop_front();
                end
            end
        end else begin
            if (abort_i && cur_exp.active) begin
                exp_q.delete();
                pushRecover(1'b1);
            end
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            else                  cur_exp = idleRec();
        end
    end

    always @(negedge clk) begin
        checkOutput("dac_o", dac_o, cur_exp.dac);
        checkOutput("dac_en_o", {28'd0, dac_en_o}, {28'd0, cur_exp.en});
        checkOutput("ctrl{pol,rdy,busy,done,abt,err}",
                    {26'd0, polarity_o, cmd_ready_o, busy_o, done_o, aborted_o, err_o},
                    {26'd0, cur_exp.pol, cur_exp.ready, cur_exp.busy, cur_exp.done,
                     cur_exp.aborted, cur_exp.err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] w,
                                 input logic [31:0] code, input logic [3:0] mask);
        cmd_valid_i = 1'b1;
        cmd_mode_i  = m;
        cmd_width_i = w;
        cmd_code_i  = code;
        cmd_mask_i  = mask;
        tick();
        cmd_valid_i = 1'b0;
        cmd_mode_i  = 2'($urandom);
        cmd_width_i = 8'($urandom);
        cmd_code_i  = $urandom;
        cmd_mask_i  = 4'($urandom);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!cmd_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: cmd_ready_o got 0 expected 1 within 200 cycles");
        end
        tick();
    endtask

    logic [7:0] t1_dac [11] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h40, 8'h40,
                                8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        cur_exp     = idleRec();
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_mode_i  = 2'b00;
        cmd_width_i = 8'd0;
        cmd_code_i  = 32'd0;
        cmd_mask_i  = 4'd0;
        abort_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'd0, cmd_ready_o}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_dac", dac_o, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] SET ramp ch0 to 0x40, width 3");
        applyStimulus(2'b01, 8'd3, 32'h0000_0040, 4'b0001);
        for (int i = 0; i < 11; i++) begin
            checkOutput("t1_ch0", {24'd0, dac_o[7:0]}, {24'd0, t1_dac[i]});
            checkOutput("t1_done", {31'd0, done_o}, {31'd0, (i == 10)});
            checkOutput("t1_pol", {31'd0, polarity_o}, 32'd0);
            tick();
        end
        checkOutput("t1_ready_after", {31'd0, cmd_ready_o}, 32'd1);
        tick();

        $display("[TB] RESET mask 1010 saturating ramp");
        applyStimulus(2'b10, 8'd2, 32'h0500_F800, 4'b1010);
        for (int c = 1; c <= 19; c++) begin
            if (c == 1) begin
                checkOutput("t2_ch3_first", {24'd0, dac_o[31:24]}, 32'h05);
                checkOutput("t2_ch1_first", {24'd0, dac_o[15:8]}, 32'h10);
            end
            if (c == 15) checkOutput("t2_ch1_f0", {24'd0, dac_o[15:8]}, 32'hF0);
            if (c == 16) begin
                checkOutput("t2_ch1_f8", {24'd0, dac_o[15:8]}, 32'hF8);
                checkOutput("t2_en", {28'd0, dac_en_o}, 32'hA);
                checkOutput("t2_ch0_ch2", {16'd0, dac_o[23:16], dac_o[7:0]}, 32'd0);
            end
            if (c == 18) checkOutput("t2_pol_pulse", {31'd0, polarity_o}, 32'd1);
            if (c == 19) checkOutput("t2_pol_recov", {31'd0, polarity_o}, 32'd0);
            if (c < 19) tick();
        end
        waitIdle();

        $display("[TB] READ all channels, width 2");
        applyStimulus(2'b00, 8'd2, 32'hDEAD_BEEF, 4'b1111);
        checkOutput("t3_dac_c1", dac_o, 32'h2020_2020);
        checkOutput("t3_busy_c1", {31'd0, busy_o}, 32'd1);
        tick();
        checkOutput("t3_dac_c2", dac_o, 32'h2020_2020);
        tick();
        checkOutput("t3_dac_c3", dac_o, 32'd0);
        checkOutput("t3_en_c3", {28'd0, dac_en_o}, 32'd0);
        waitIdle();

        $display("[TB] illegal commands");
        applyStimulus(2'b11, 8'd5, 32'h1111_1111, 4'b1111);
        checkOutput("t4_err_mode", {31'd0, err_o}, 32'd1);
        checkOutput("t4_busy_mode", {31'd0, busy_o}, 32'd0);
        tick();
        checkOutput("t4_err_clear", {31'd0, err_o}, 32'd0);
        applyStimulus(2'b01, 8'd0, 32'h1111_1111, 4'b1111);
        checkOutput("t4_err_width", {31'd0, err_o}, 32'd1);
        checkOutput("t4_ready_width", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        tick();

        $display("[TB] abort on third hold cycle");
        applyStimulus(2'b01, 8'd10, 32'h0000_0030, 4'b0001);
        repeat (5) tick();
        abort_i = 1'b1;
        checkOutput("t5_hold_val", {24'd0, dac_o[7:0]}, 32'h30);
        tick();
        abort_i = 1'b0;
        checkOutput("t5_recov_dac", dac_o, 32'd0);
        checkOutput("t5_recov_busy", {31'd0, busy_o}, 32'd1);
        repeat (3) tick();
        checkOutput("t5_done", {31'd0, done_o}, 32'd1);
        checkOutput("t5_aborted", {31'd0, aborted_o}, 32'd1);
        waitIdle();

        $display("[TB] abort with command in idle");
        abort_i = 1'b1;
        applyStimulus(2'b01, 8'd2, 32'h0000_0020, 4'b0001);
        abort_i = 1'b0;
        checkOutput("t6_cmd_wins", {31'd0, busy_o}, 32'd1);
        waitIdle();

        $display("[TB] reset during hold");
        applyStimulus(2'b00, 8'd20, 32'd0, 4'b1111);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_dac", dac_o, 32'd0);
        checkOutput("t7_en", {28'd0, dac_en_o}, 32'd0);
        checkOutput("t7_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("t7_ready", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            cmd_valid_i = ($urandom % 4 == 0);
            cmd_mode_i  = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
            cmd_width_i = ($urandom % 16 == 0) ? 8'd0 : 8'(1 + $urandom % 12);
            cmd_code_i  = $urandom;
            cmd_mask_i  = 4'($urandom);
            abort_i     = ($urandom % 25 == 0);
            tick();
        end
        cmd_valid_i = 1'b0;
        abort_i     = 1'b0;
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
